showcase0_result_fifo: RTL and testbench

//   Downstream consumer of the Showcase0 stage. Captures its per-cycle results
//   (sum c, cmp_0..cmp_5 flags, sc_signal) into a small FIFO with a valid/ready

---
 rtl/showcase0_result_fifo.sv | 104 ++++++++++
 tb/tb_showcase0_result_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/showcase0_result_fifo.sv
// Purpose : buffers Showcase0 results {cmp, sc, c} for a slower sink; keeps a running sum
//           of accepted c and a saturating count of samples dropped on overflow.
// Latency : a sample pushed at edge N is visible on out_data/out_vld after edge N (no bypass).
// Backpr. : the producer cannot be stalled; a sample arriving while full (and no pop) is dropped.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_vld/in_c/in_cmp/in_sc  producer sample (no ready)
//   clr                  synchronous clear of pointers, level, acc, drop_cnt
//   out_data/out_vld/out_rd   FIFO head {cmp, sc, c} with valid/ready handshake
//   level/full/empty     occupancy status
//   acc                  wrapping sum of accepted in_c
//   drop_cnt             saturating count of dropped samples
module showcase0_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_vld,
  input  logic [DATA_WIDTH-1:0]          in_c,
  input  logic [5:0]                     in_cmp,
  input  logic [7:0]                     in_sc,
  input  logic                           clr,
  output logic [DATA_WIDTH+13:0]         out_data,
  output logic                           out_vld,
  input  logic                           out_rd,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           full,
  output logic                           empty,
  output logic [DATA_WIDTH-1:0]          acc,
  output logic [CNT_WIDTH-1:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int OW = DATA_WIDTH + 14;

  logic [OW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic pop;
  logic push;
  logic drop;

  // Status is decoded from the occupancy count rather than pointer compare,
  // which keeps full/empty unambiguous when the pointers are equal.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign out_vld = ~empty;

  assign pop  = out_vld & out_rd;
  // A slot being freed by this cycle's pop can be refilled in the same cycle.
  assign push = in_vld & (~full | pop);
  assign drop = in_vld & full & ~pop;

  // Head is read combinationally from the registered read pointer; zero when
  // empty so the sink never sees stale memory contents.
  assign out_data = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately not reset. clr blocks the write so a cleared
  // FIFO does not carry a half-accepted sample.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= {in_cmp, in_sc, in_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      acc      <= '0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      acc      <= '0;
      drop_cnt <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        acc    <= acc + in_c;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop && (drop_cnt != {CNT_WIDTH{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_showcase0_result_fifo.sv
module tb_showcase0_result_fifo;

  localparam int DW = 32;
  localparam int OW = DW + 14;

  logic          clk;
  logic          rst_n;
  logic          in_vld;
  logic [DW-1:0] in_c;
  logic [5:0]    in_cmp;
  logic [7:0]    in_sc;
  logic          clr;
  logic          out_rd;

  logic [OW-1:0] out_data;
  logic          out_vld;
  logic [2:0]    level;
  logic          full;
  logic          empty;
  logic [DW-1:0] acc;
  logic [15:0]   drop_cnt;

  // Second instance only to observe drop counter saturation at 2 bits.
  logic [OW-1:0] s_out_data;
  logic          s_out_vld;
  logic [2:0]    s_level;
  logic          s_full;
  logic          s_empty;
  logic [DW-1:0] s_acc;
  logic [1:0]    s_drop_cnt;

  showcase0_result_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_c(in_c), .in_cmp(in_cmp),
    .in_sc(in_sc), .clr(clr), .out_data(out_data), .out_vld(out_vld),
    .out_rd(out_rd), .level(level), .full(full), .empty(empty), .acc(acc),
    .drop_cnt(drop_cnt)
  );

  showcase0_result_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_c(in_c), .in_cmp(in_cmp),
    .in_sc(in_sc), .clr(clr), .out_data(s_out_data), .out_vld(s_out_vld),
    .out_rd(out_rd), .level(s_level), .full(s_full), .empty(s_empty), .acc(s_acc),
    .drop_cnt(s_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [OW-1:0] sb[$];
  int            m_level = 0;
  logic [DW-1:0] m_acc   = '0;
  int            m_drop  = 0;
  int            m_drop2 = 0;

  task automatic model_reset();
    sb.delete();
    m_level = 0;
    m_acc   = '0;
    m_drop  = 0;
    m_drop2 = 0;
  endtask

  // Drive one cycle of stimulus, update the model, advance to 1 time unit past
  // the edge and return inputs to idle. Popping the scoreboard is left to the
  // caller, which compares the head before issuing out_rd.
  task automatic step(input logic v, input logic [DW-1:0] c, input logic [5:0] cm,
                      input logic [7:0] s, input logic rd, input logic cl);
    bit pop_m, push_m, drop_m;
    in_vld = v; in_c = c; in_cmp = cm; in_sc = s; out_rd = rd; clr = cl;
    if (cl) begin
      model_reset();
    end else begin
      pop_m  = rd && (m_level > 0);
      push_m = v && ((m_level < 4) || pop_m);
      drop_m = v && (m_level == 4) && !pop_m;
      if (push_m) begin
        sb.push_back({cm, s, c});
        m_acc = m_acc + c;
      end
      if (push_m && !pop_m) m_level++;
      if (pop_m && !push_m) m_level--;
      if (drop_m) begin
        m_drop++;
        if (m_drop2 < 3) m_drop2++;
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0; out_rd = 1'b0; clr = 1'b0;
  endtask

  task automatic test_single();
    logic [OW-1:0] exp;
    in_vld = 1'b1; in_c = 32'd5; in_cmp = 6'b001100; in_sc = 8'h04;
    #1;
    total_cnt++; if (out_vld !== 1'b0) $display("FAIL single_no_bypass: got %0b want 0", out_vld); else pass_cnt++;
    step(1'b1, 32'd5, 6'b001100, 8'h04, 1'b0, 1'b0);
    exp = {6'b001100, 8'h04, 32'd5};
    total_cnt++; if (out_vld !== 1'b1) $display("FAIL single_vld: got %0b want 1", out_vld); else pass_cnt++;
    total_cnt++; if (out_data !== exp) $display("FAIL single_data: got %h want %h", out_data, exp); else pass_cnt++;
    total_cnt++; if (out_data !== sb[0]) $display("FAIL single_sb: got %h want %h", out_data, sb[0]); else pass_cnt++;
    total_cnt++; if (acc !== 32'd5) $display("FAIL single_acc: got %0d want 5", acc); else pass_cnt++;
    total_cnt++; if (level !== 3'd1) $display("FAIL single_level: got %0d want 1", level); else pass_cnt++;
  endtask

  // Asynchronous reset asserted mid-cycle with an entry in flight.
  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total_cnt++; if (out_vld !== 1'b0) $display("FAIL reset_vld: got %0b want 0", out_vld); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
    total_cnt++; if (acc !== 32'd0) $display("FAIL reset_acc: got %0d want 0", acc); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    total_cnt++; if ({empty, full} !== 2'b10) $display("FAIL reset_flags: got %b want 10", {empty, full}); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else pass_cnt++;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_overflow();
    logic [OW-1:0] exp;
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 6'(i), 8'(i + 16), 1'b0, 1'b0);
    total_cnt++; if (full !== 1'b1) $display("FAIL fill_full: got %0b want 1", full); else pass_cnt++;
    total_cnt++; if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 16'd2) $display("FAIL fill_drop: got %0d want 2", drop_cnt); else pass_cnt++;
    total_cnt++; if (acc !== 32'd10) $display("FAIL fill_acc: got %0d want 10", acc); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      exp = sb.pop_front();
      total_cnt++; if (out_data !== exp) $display("FAIL fill_drain_data%0d: got %h want %h", i, out_data, exp); else pass_cnt++;
      total_cnt++; if (out_data[DW-1:0] !== DW'(i)) $display("FAIL fill_drain_order%0d: got %0d want %0d", i, out_data[DW-1:0], i); else pass_cnt++;
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    total_cnt++; if ({empty, out_vld} !== 2'b10) $display("FAIL fill_empty: got %b want 10", {empty, out_vld}); else pass_cnt++;
    // Read while empty must be ignored.
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    total_cnt++; if (level !== 3'd0) $display("FAIL empty_rd_level: got %0d want 0", level); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [OW-1:0] exp;
    for (int i = 11; i <= 14; i++) step(1'b1, DW'(i), 6'h2A, 8'(i), 1'b0, 1'b0);
    exp = sb.pop_front();
    total_cnt++; if (out_data !== exp) $display("FAIL fpp_head: got %h want %h", out_data, exp); else pass_cnt++;
    step(1'b1, 32'd9, 6'h15, 8'h99, 1'b1, 1'b0);
    total_cnt++; if (level !== 3'd4) $display("FAIL fpp_level: got %0d want 4", level); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 16'(m_drop)) $display("FAIL fpp_drop: got %0d want %0d", drop_cnt, m_drop); else pass_cnt++;
    total_cnt++; if (acc !== m_acc) $display("FAIL fpp_acc: got %0d want %0d", acc, m_acc); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      total_cnt++; if (out_data !== exp) $display("FAIL fpp_drain%0d: got %h want %h", i, out_data, exp); else pass_cnt++;
      if (i == 3) begin
        total_cnt++; if (out_data[DW-1:0] !== 32'd9) $display("FAIL fpp_last: got %0d want 9", out_data[DW-1:0]); else pass_cnt++;
      end
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap_sat();
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, 6'h01, 8'h01, 1'b0, 1'b0);
    total_cnt++; if (acc !== 32'hFFFF_FFFF) $display("FAIL wrap_acc_max: got %h want ffffffff", acc); else pass_cnt++;
    step(1'b1, 32'd2, 6'h02, 8'h02, 1'b0, 1'b0);
    total_cnt++; if (acc !== 32'd1) $display("FAIL wrap_acc: got %h want 1", acc); else pass_cnt++;
    step(1'b1, 32'd0, 6'h03, 8'h03, 1'b0, 1'b0);
    step(1'b1, 32'd0, 6'h04, 8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'd7, 6'h05, 8'h05, 1'b0, 1'b0);
    total_cnt++; if (drop_cnt !== 16'd5) $display("FAIL sat_main_drop: got %0d want 5", drop_cnt); else pass_cnt++;
    total_cnt++; if (s_drop_cnt !== 2'd3) $display("FAIL sat_drop: got %0d want 3", s_drop_cnt); else pass_cnt++;
    total_cnt++; if (s_drop_cnt !== 2'(m_drop2)) $display("FAIL sat_model: got %0d want %0d", s_drop_cnt, m_drop2); else pass_cnt++;
    total_cnt++; if (acc !== 32'd1) $display("FAIL sat_acc_hold: got %0d want 1", acc); else pass_cnt++;
  endtask

  task automatic test_clr();
    logic [OW-1:0] exp;
    // Still full from the previous scenario: clr together with push and pop.
    step(1'b1, 32'd77, 6'h3F, 8'hFF, 1'b1, 1'b1);
    total_cnt++; if (level !== 3'd0) $display("FAIL clr_level: got %0d want 0", level); else pass_cnt++;
    total_cnt++; if (acc !== 32'd0) $display("FAIL clr_acc: got %0d want 0", acc); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 16'd0) $display("FAIL clr_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    total_cnt++; if (out_vld !== 1'b0) $display("FAIL clr_vld: got %0b want 0", out_vld); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL clr_data: got %h want 0", out_data); else pass_cnt++;
    step(1'b1, 32'd3, 6'h07, 8'h33, 1'b0, 1'b0);
    exp = sb.pop_front();
    total_cnt++; if (out_data !== exp) $display("FAIL clr_after_push: got %h want %h", out_data, exp); else pass_cnt++;
    total_cnt++; if (acc !== 32'd3) $display("FAIL clr_after_acc: got %0d want 3", acc); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_c = '0; in_cmp = '0; in_sc = '0; clr = 1'b0; out_rd = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_single();
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_sat();
    test_clr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
